pid_step_sequencer: RTL and testbench

//  Per-sample PID sequencer for the temperature loop. Runs on a fixed sample period.

---
 rtl/pid_pkg.sv | 36 +++
 rtl/pid_sample_timer.sv | 38 +++
 rtl/pid_step_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pid_step_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared states, widths and integrator clamp for the PID step sequencer
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        MUL_P,
        MUL_I,
        MUL_D,
        OUT
    } pid_state_e;

    localparam int ERRW  = 11;
    localparam int DERW  = 12;
    localparam int PRODW = 23;
    localparam int ACCW  = 25;

    // Saturate a widened integrator sum back into the error width.
    function automatic logic signed [ERRW-1:0] clamp_integ(
        input logic signed [DERW-1:0] v,
        input int                     lim
    );
        logic signed [DERW-1:0] hi;
        logic signed [DERW-1:0] lo;
        hi = DERW'(lim);
        lo = -hi;
        if (v > hi) begin
            return ERRW'(hi);
        end else if (v < lo) begin
            return ERRW'(lo);
        end else begin
            return ERRW'(v);
        end
    endfunction

endpackage

// File: rtl/pid_sample_timer.sv
// rtl/pid_sample_timer.sv - free-running sample period counter, held at zero while disabled
module pid_sample_timer #(
    parameter int SAMPLE_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pid_step_sequencer.sv
// rtl/pid_step_sequencer.sv - per-sample PID sequencer sharing one signed multiplier over P, I and D
module pid_step_sequencer
    import pid_pkg::*;
#(
    parameter int SAMPLE_DIV = 50000,
    parameter int TW         = 10,
    parameter int OW         = 10,
    parameter int ILIM       = 511,
    parameter int SHIFT      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [TW-1:0] set_temp,
    input  logic [TW-1:0] cur_temp,
    input  logic [TW-1:0] p_pa,
    input  logic [TW-1:0] i_pa,
    input  logic [TW-1:0] d_pa,
    output logic [OW-1:0] duty,
    output logic          duty_valid,
    output logic          busy,
    output logic          sat,
    output logic          overrun
);

    logic tick;

    pid_sample_timer #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    pid_state_e state_q, state_d;

    logic [TW-1:0]           kp_q, kp_d;
    logic [TW-1:0]           ki_q, ki_d;
    logic [TW-1:0]           kd_q, kd_d;
    logic signed [ERRW-1:0]  err_q, err_d;
    logic signed [ERRW-1:0]  err_prev_q, err_prev_d;
    logic signed [ERRW-1:0]  integ_q, integ_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [OW-1:0]           duty_q, duty_d;
    logic                    sat_q, sat_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    logic signed [DERW-1:0]  integ_sum;
    logic signed [ERRW-1:0]  integ_new;
    logic signed [DERW-1:0]  deriv;
    logic signed [ERRW-1:0]  mul_a;
    logic signed [DERW-1:0]  mul_b;
    logic signed [PRODW-1:0] prod;
    logic signed [ACCW-1:0]  prod_ext;
    logic signed [ACCW-1:0]  acc_sum;
    logic signed [ACCW-1:0]  y;

    assign integ_sum = $signed({integ_q[ERRW-1], integ_q}) + $signed({err_q[ERRW-1], err_q});
    assign integ_new = clamp_integ(integ_sum, ILIM);
    assign deriv     = $signed({err_q[ERRW-1], err_q}) - $signed({err_prev_q[ERRW-1], err_prev_q});

    // Gains are unsigned, so they enter the multiplier with a zero sign bit.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            MUL_P: begin
                mul_a = $signed({1'b0, kp_q});
                mul_b = $signed({err_q[ERRW-1], err_q});
            end
            MUL_I: begin
                mul_a = $signed({1'b0, ki_q});
                mul_b = $signed({integ_new[ERRW-1], integ_new});
            end
            MUL_D: begin
                mul_a = $signed({1'b0, kd_q});
                mul_b = deriv;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    assign prod     = mul_a * mul_b;
    assign prod_ext = $signed({{(ACCW-PRODW){prod[PRODW-1]}}, prod});
    assign acc_sum  = acc_q + prod_ext;
    assign y        = acc_sum >>> SHIFT;

    // The final sum is scaled and clamped while in MUL_D so duty lands in the OUT cycle.
    always_comb begin
        state_d    = state_q;
        kp_d       = kp_q;
        ki_d       = ki_q;
        kd_d       = kd_q;
        err_d      = err_q;
        err_prev_d = err_prev_q;
        integ_d    = integ_q;
        acc_d      = acc_q;
        duty_d     = duty_q;
        sat_d      = sat_q;
        valid_d    = 1'b0;
        overrun_d  = overrun_q | (tick && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (tick && en) begin
                    state_d = LATCH;
                end else if (!en) begin
                    integ_d    = '0;
                    err_prev_d = '0;
                end
            end
            LATCH: begin
                err_d   = $signed({1'b0, set_temp}) - $signed({1'b0, cur_temp});
                kp_d    = p_pa;
                ki_d    = i_pa;
                kd_d    = d_pa;
                state_d = MUL_P;
            end
            MUL_P: begin
                acc_d   = prod_ext;
                state_d = MUL_I;
            end
            MUL_I: begin
                integ_d = integ_new;
                acc_d   = acc_sum;
                state_d = MUL_D;
            end
            MUL_D: begin
                acc_d      = acc_sum;
                err_prev_d = err_q;
                valid_d    = 1'b1;
                if (y[ACCW-1]) begin
                    duty_d = '0;
                    sat_d  = 1'b1;
                end else if (|y[ACCW-2:OW]) begin
                    duty_d = '1;
                    sat_d  = 1'b1;
                end else begin
                    duty_d = y[OW-1:0];
                    sat_d  = 1'b0;
                end
                state_d = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            kp_q       <= '0;
            ki_q       <= '0;
            kd_q       <= '0;
            err_q      <= '0;
            err_prev_q <= '0;
            integ_q    <= '0;
            acc_q      <= '0;
            duty_q     <= '0;
            sat_q      <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            kd_q       <= kd_d;
            err_q      <= err_d;
            err_prev_q <= err_prev_d;
            integ_q    <= integ_d;
            acc_q      <= acc_d;
            duty_q     <= duty_d;
            sat_q      <= sat_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = valid_q;
    assign busy       = (state_q != IDLE);
    assign sat        = sat_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pid_step_sequencer.sv
// tb/tb_pid_step_sequencer.sv - directed scoreboard bench for pid_step_sequencer
module tb_pid_step_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [9:0] set_temp = '0;
    logic [9:0] cur_temp = '0;
    logic [9:0] p_pa = '0;
    logic [9:0] i_pa = '0;
    logic [9:0] d_pa = '0;

    logic [9:0] duty;
    logic       duty_valid, busy, sat, overrun;
    logic [9:0] o_duty;
    logic       o_duty_valid, o_busy, o_sat, o_overrun;

    pid_step_sequencer #(.SAMPLE_DIV(16), .SHIFT(6)) dut (
        .clk(clk), .rst(rst), .en(en),
        .set_temp(set_temp), .cur_temp(cur_temp),
        .p_pa(p_pa), .i_pa(i_pa), .d_pa(d_pa),
        .duty(duty), .duty_valid(duty_valid), .busy(busy),
        .sat(sat), .overrun(overrun)
    );

    pid_step_sequencer #(.SAMPLE_DIV(4), .SHIFT(6)) u_ovr (
        .clk(clk), .rst(rst), .en(en),
        .set_temp(set_temp), .cur_temp(cur_temp),
        .p_pa(p_pa), .i_pa(i_pa), .d_pa(d_pa),
        .duty(o_duty), .duty_valid(o_duty_valid), .busy(o_busy),
        .sat(o_sat), .overrun(o_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int m_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || !en) m_cnt <= 0;
        else            m_cnt <= (m_cnt == 15) ? 0 : m_cnt + 1;
    end

    typedef struct {
        int duty;
        int sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int integ_m = 0;
    int eprev_m = 0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (!(en && m_cnt == 15) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", int'(n < 40), 1);
    endtask

    task automatic clear_hist();
        en = 1'b0;
        repeat (3) @(negedge clk);
        integ_m = 0;
        eprev_m = 0;
        en = 1'b1;
    endtask

    // spec_duty/spec_sat < 0 means take the expectation from the reference model.
    task automatic sample(input int s, input int c, input int kp, input int ki, input int kd,
                          input int spec_duty, input int spec_sat, input bit chg);
        int   err, acc, y, md, ms, n;
        exp_t e;
        set_temp = 10'(s);
        cur_temp = 10'(c);
        p_pa = 10'(kp);
        i_pa = 10'(ki);
        d_pa = 10'(kd);
        wait_tick();
        err = s - c;
        integ_m = integ_m + err;
        if (integ_m > 511)  integ_m = 511;
        if (integ_m < -511) integ_m = -511;
        acc = kp * err + ki * integ_m + kd * (err - eprev_m);
        eprev_m = err;
        y = acc >>> 6;
        if (y < 0)         begin md = 0;    ms = 1; end
        else if (y > 1023) begin md = 1023; ms = 1; end
        else               begin md = y;    ms = 0; end
        e.duty = (spec_duty >= 0) ? spec_duty : md;
        e.sat  = (spec_sat  >= 0) ? spec_sat  : ms;
        e.cyc  = cyc;
        q.push_back(e);
        if (chg) begin
            repeat (3) @(negedge clk);
            p_pa = '0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!duty_valid && n < 12);
        e = q.pop_front();
        check("valid_seen", int'(duty_valid), 1);
        if (duty_valid) begin
            check("duty", int'(duty), e.duty);
            check("sat", int'(sat), e.sat);
            check("latency", cyc - e.cyc, 5);
        end
        @(negedge clk);
        check("valid_one_cycle", int'(duty_valid), 0);
    endtask

    initial begin
        int nv;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_duty", int'(duty), 0);
        check("rst_valid", int'(duty_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_ovr_overrun", int'(o_overrun), 0);
        rst = 1'b0;
        en  = 1'b1;

        sample(300, 290, 70, 0, 0, 10, 0, 1'b0);
        clear_hist();
        sample(300, 290, 70, 10, 4, 13, 0, 1'b0);
        clear_hist();
        sample(200, 300, 70, 0, 0, 0, 1, 1'b0);
        clear_hist();
        for (int i = 1; i <= 7; i++) begin
            sample(400, 300, 0, 10, 0, (i == 6) ? 79 : -1, (i == 6) ? 0 : -1, 1'b0);
        end
        clear_hist();
        sample(600, 100, 1023, 0, 0, 1023, 1, 1'b1);
        check("no_overrun_div16", int'(overrun), 0);
        check("overrun_div4", int'(o_overrun), 1);

        p_pa = 10'd70;
        wait_tick();
        repeat (2) @(negedge clk);
        check("busy_in_mul_p", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_duty", int'(duty), 0);
        check("abort_valid", int'(duty_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_sat", int'(sat), 0);
        check("abort_ovr_overrun", int'(o_overrun), 0);
        rst = 1'b0;
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (duty_valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        check("overrun_div4_again", int'(o_overrun), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
